rv32_control_unit: RTL and testbench

// - Decode-stage main/ALU decoder of the kianv 5-stage RV32IM pipeline.
// - Maps opcode/funct fields of InstrD to the control bundle that the datapath registers into the D->E stage.
// - Decode is purely combinational. The only state is a sticky illegal-instruction flag used for debug.

---
 rtl/rv32_control_unit_pkg.sv | 97 +++++++++
 rtl/rv32_control_unit_alu_decoder.sv | 75 +++++++
 rtl/rv32_control_unit.sv | 166 ++++++++++++++++
 tb/tb_rv32_control_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_control_unit_pkg.sv
// Shared types and encodings for the RV32IM decode-stage control unit.
// Holds the control enums, RV32 opcode/funct3 constants and the NOP control bundle.
package rv32_control_unit_pkg;

    typedef enum logic {PC_PLUS_IMM, ALU_RESULT} PCTargetSrc_t;

    typedef enum logic [1:0] {RESULT_ALU, RESULT_MEM, RESULT_PC4, RESULT_CSR} ResultSrc_t;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
        ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
    } AluControl_t;

    typedef enum logic [1:0] {SRCA_RS1, SRCA_PC, SRCA_ZERO} AluSrcA_t;
    typedef enum logic {SRCB_RS2, SRCB_IMM} AluSrcB_t;
    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} ImmSrc_t;
    typedef enum logic [1:0] {STORE_SB, STORE_SH, STORE_SW} StoreOp_t;
    typedef enum logic [2:0] {LOAD_LB, LOAD_LH, LOAD_LW, LOAD_LBU, LOAD_LHU} LoadOp_t;
    typedef enum logic [2:0] {
        CSR_NONE, CSR_RW, CSR_RS, CSR_RC, CSR_RWI, CSR_RSI, CSR_RCI
    } CsrOp_t;

    localparam logic [6:0] OPC_BUBBLE = 7'b0000000;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // funct3 for OP / OP-IMM (also the M-extension slot order)
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB   = 3'b000;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_LHU  = 3'b101;

    localparam logic [2:0] F3_SB   = 3'b000;
    localparam logic [2:0] F3_SH   = 3'b001;
    localparam logic [2:0] F3_SW   = 3'b010;

    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [2:0] F3_PRIV   = 3'b000;
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    typedef struct packed {
        PCTargetSrc_t pctarget;
        ResultSrc_t   result;
        logic         memwrite;
        logic         jump;
        logic         branch;
        logic         regwrite;
        AluSrcA_t     srca;
        AluSrcB_t     srcb;
        ImmSrc_t      immsrc;
        StoreOp_t     storeop;
        LoadOp_t      loadop;
        CsrOp_t       csrop;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        pctarget: PC_PLUS_IMM, result: RESULT_ALU,
        memwrite: 1'b0, jump: 1'b0, branch: 1'b0, regwrite: 1'b0,
        srca: SRCA_RS1, srcb: SRCB_IMM, immsrc: IMM_I,
        storeop: STORE_SW, loadop: LOAD_LW, csrop: CSR_NONE
    };

endpackage

// File: rtl/rv32_control_unit_alu_decoder.sv
// ALU operation decoder: opcode/funct fields -> AluControlD.
// Returns ADD for anything that is not OP, OP-IMM or BRANCH.
module rv32_control_unit_alu_decoder
    import rv32_control_unit_pkg::*;
#(
    parameter bit HAS_M = 1'b1
) (
    input  logic [6:0]  opD,
    input  logic [2:0]  funct3D,
    input  logic        funct7b5D,
    input  logic        funct7b1D,
    input  logic        immb10D,
    output AluControl_t AluControlD
);

    always_comb begin
        AluControlD = ALU_ADD;
        case (opD)
            OPC_OPIMM: begin
                // funct7b5 is ignored here: there is no SUBI
                case (funct3D)
                    F3_ADD:  AluControlD = ALU_ADD;
                    F3_SLL:  AluControlD = ALU_SLL;
                    F3_SLT:  AluControlD = ALU_SLT;
                    F3_SLTU: AluControlD = ALU_SLTU;
                    F3_XOR:  AluControlD = ALU_XOR;
                    F3_SR:   AluControlD = immb10D ? ALU_SRA : ALU_SRL;
                    F3_OR:   AluControlD = ALU_OR;
                    F3_AND:  AluControlD = ALU_AND;
                    default: AluControlD = ALU_ADD;
                endcase
            end
            OPC_OP: begin
                if (funct7b1D && HAS_M) begin
                    case (funct3D)
                        F3_ADD:  AluControlD = ALU_MUL;
                        F3_SLL:  AluControlD = ALU_MULH;
                        F3_SLT:  AluControlD = ALU_MULHSU;
                        F3_SLTU: AluControlD = ALU_MULHU;
                        F3_XOR:  AluControlD = ALU_DIV;
                        F3_SR:   AluControlD = ALU_DIVU;
                        F3_OR:   AluControlD = ALU_REM;
                        F3_AND:  AluControlD = ALU_REMU;
                        default: AluControlD = ALU_ADD;
                    endcase
                end else begin
                    case (funct3D)
                        F3_ADD:  AluControlD = funct7b5D ? ALU_SUB : ALU_ADD;
                        F3_SLL:  AluControlD = ALU_SLL;
                        F3_SLT:  AluControlD = ALU_SLT;
                        F3_SLTU: AluControlD = ALU_SLTU;
                        F3_XOR:  AluControlD = ALU_XOR;
                        F3_SR:   AluControlD = funct7b5D ? ALU_SRA : ALU_SRL;
                        F3_OR:   AluControlD = ALU_OR;
                        F3_AND:  AluControlD = ALU_AND;
                        default: AluControlD = ALU_ADD;
                    endcase
                end
            end
            OPC_BRANCH: begin
                case (funct3D)
                    F3_BEQ:  AluControlD = ALU_BEQ;
                    F3_BNE:  AluControlD = ALU_BNE;
                    F3_BLT:  AluControlD = ALU_BLT;
                    F3_BGE:  AluControlD = ALU_BGE;
                    F3_BLTU: AluControlD = ALU_BLTU;
                    F3_BGEU: AluControlD = ALU_BGEU;
                    default: AluControlD = ALU_ADD;
                endcase
            end
            default: AluControlD = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv32_control_unit.sv
// Decode-stage main decoder of the RV32IM pipeline: InstrD fields -> control bundle.
// Purely combinational apart from the sticky illegal-instruction debug flag.
module rv32_control_unit
    import rv32_control_unit_pkg::*;
#(
    parameter bit HAS_M = 1'b1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [6:0]   opD,
    input  logic [2:0]   funct3D,
    input  logic         funct7b5D,
    input  logic         funct7b1D,
    input  logic         immb10D,
    output PCTargetSrc_t PCTargetSrcD,
    output ResultSrc_t   ResultSrcD,
    output logic         MemWriteD,
    output logic         JumpD,
    output logic         BranchD,
    output logic         RegWriteD,
    output logic         CsrInstrIncD,
    output AluControl_t  AluControlD,
    output AluSrcA_t     AluSrcAD,
    output AluSrcB_t     AluSrcBD,
    output ImmSrc_t      ImmSrcD,
    output StoreOp_t     StoreOpD,
    output LoadOp_t      LoadOpD,
    output CsrOp_t       CsrOpD,
    output logic         illegal_o,
    output logic         illegal_seen
);

    AluControl_t alu_dec;
    ctrl_t       ctrl;
    logic        illegal;
    logic        bubble;

    rv32_control_unit_alu_decoder #(
        .HAS_M(HAS_M)
    ) u_alu_dec (
        .opD        (opD),
        .funct3D    (funct3D),
        .funct7b5D  (funct7b5D),
        .funct7b1D  (funct7b1D),
        .immb10D    (immb10D),
        .AluControlD(alu_dec)
    );

    always_comb begin
        ctrl    = CTRL_NOP;
        illegal = 1'b0;
        case (opD)
            OPC_LUI: begin
                ctrl.srca     = SRCA_ZERO;
                ctrl.immsrc   = IMM_U;
                ctrl.regwrite = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl.srca     = SRCA_PC;
                ctrl.immsrc   = IMM_U;
                ctrl.regwrite = 1'b1;
            end
            OPC_JAL: begin
                ctrl.immsrc   = IMM_J;
                ctrl.jump     = 1'b1;
                ctrl.result   = RESULT_PC4;
                ctrl.regwrite = 1'b1;
            end
            OPC_JALR: begin
                ctrl.jump     = 1'b1;
                ctrl.pctarget = ALU_RESULT;
                ctrl.result   = RESULT_PC4;
                ctrl.regwrite = 1'b1;
                illegal       = (funct3D != F3_JALR);
            end
            OPC_BRANCH: begin
                ctrl.immsrc = IMM_B;
                ctrl.srcb   = SRCB_RS2;
                ctrl.branch = 1'b1;
                case (funct3D)
                    F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: illegal = 1'b0;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                ctrl.result   = RESULT_MEM;
                ctrl.regwrite = 1'b1;
                case (funct3D)
                    F3_LB:   ctrl.loadop = LOAD_LB;
                    F3_LH:   ctrl.loadop = LOAD_LH;
                    F3_LW:   ctrl.loadop = LOAD_LW;
                    F3_LBU:  ctrl.loadop = LOAD_LBU;
                    F3_LHU:  ctrl.loadop = LOAD_LHU;
                    default: illegal     = 1'b1;
                endcase
            end
            OPC_STORE: begin
                ctrl.immsrc   = IMM_S;
                ctrl.memwrite = 1'b1;
                case (funct3D)
                    F3_SB:   ctrl.storeop = STORE_SB;
                    F3_SH:   ctrl.storeop = STORE_SH;
                    F3_SW:   ctrl.storeop = STORE_SW;
                    default: illegal      = 1'b1;
                endcase
            end
            OPC_OPIMM: ctrl.regwrite = 1'b1;
            OPC_OP: begin
                ctrl.srcb     = SRCB_RS2;
                ctrl.regwrite = 1'b1;
                illegal       = funct7b1D && !HAS_M;
            end
            OPC_SYSTEM: begin
                case (funct3D)
                    F3_PRIV:   ctrl.csrop = CSR_NONE;
                    F3_CSRRW:  ctrl.csrop = CSR_RW;
                    F3_CSRRS:  ctrl.csrop = CSR_RS;
                    F3_CSRRC:  ctrl.csrop = CSR_RC;
                    F3_CSRRWI: ctrl.csrop = CSR_RWI;
                    F3_CSRRSI: ctrl.csrop = CSR_RSI;
                    F3_CSRRCI: ctrl.csrop = CSR_RCI;
                    default:   illegal    = 1'b1;
                endcase
                // ECALL/EBREAK keep the NOP bundle; CSR ops write rd from the CSR path
                if (ctrl.csrop != CSR_NONE) begin
                    ctrl.result   = RESULT_CSR;
                    ctrl.regwrite = 1'b1;
                end
            end
            OPC_FENCE, OPC_BUBBLE: ctrl = CTRL_NOP;
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            ctrl = CTRL_NOP;
        end
    end

    assign bubble = (opD == OPC_BUBBLE);

    // Enables are gated by reset; the data-path selects pass through unchanged
    assign RegWriteD    = ctrl.regwrite & ~resetn;
    assign MemWriteD    = ctrl.memwrite & ~resetn;
    assign JumpD        = ctrl.jump & ~resetn;
    assign BranchD      = ctrl.branch & ~resetn;
    assign CsrInstrIncD = ~illegal & ~bubble & ~resetn;

    assign PCTargetSrcD = ctrl.pctarget;
    assign ResultSrcD   = ctrl.result;
    assign AluSrcAD     = ctrl.srca;
    assign AluSrcBD     = ctrl.srcb;
    assign ImmSrcD      = ctrl.immsrc;
    assign StoreOpD     = ctrl.storeop;
    assign LoadOpD      = ctrl.loadop;
    assign CsrOpD       = ctrl.csrop;
    assign AluControlD  = illegal ? ALU_ADD : alu_dec;
    assign illegal_o    = illegal;

    always_ff @(posedge clk) begin
        if (resetn) begin
            illegal_seen <= 1'b0;
        end else if (illegal_o) begin
            illegal_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rv32_control_unit.sv
// Self-checking bench for rv32_control_unit: instruction vectors with hand-derived
// control bundles pushed to a scoreboard and compared one cycle later.
module tb_rv32_control_unit;
    import rv32_control_unit_pkg::*;

    typedef struct packed {
        logic         regwrite;
        logic         memwrite;
        logic         jump;
        logic         branch;
        logic         inc;
        logic         illegal;
        PCTargetSrc_t pct;
        ResultSrc_t   res;
        AluControl_t  alu;
        AluSrcA_t     srca;
        AluSrcB_t     srcb;
        ImmSrc_t      imm;
        StoreOp_t     st;
        LoadOp_t      ld;
        CsrOp_t       csr;
    } obs_t;

    typedef struct {
        logic [31:0] ins;
        obs_t        exp;
        bit          nom;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [31:0] instr = '0;

    int checks = 0;
    int passed = 0;

    vec_t sbq[$];
    logic seenq[$];

    PCTargetSrc_t pct_m, pct_n;
    ResultSrc_t   res_m, res_n;
    logic         mw_m, mw_n, j_m, j_n, br_m, br_n, rw_m, rw_n, inc_m, inc_n;
    AluControl_t  alu_m, alu_n;
    AluSrcA_t     sa_m, sa_n;
    AluSrcB_t     sb_m, sb_n;
    ImmSrc_t      imm_m, imm_n;
    StoreOp_t     st_m, st_n;
    LoadOp_t      ld_m, ld_n;
    CsrOp_t       csr_m, csr_n;
    logic         ill_m, ill_n, seen_m, seen_n;

    obs_t got_m, got_n;
    assign got_m = {rw_m, mw_m, j_m, br_m, inc_m, ill_m, pct_m, res_m, alu_m, sa_m, sb_m, imm_m, st_m, ld_m, csr_m};
    assign got_n = {rw_n, mw_n, j_n, br_n, inc_n, ill_n, pct_n, res_n, alu_n, sa_n, sb_n, imm_n, st_n, ld_n, csr_n};

    always #5 clk = ~clk;

    rv32_control_unit #(.HAS_M(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .opD(instr[6:0]), .funct3D(instr[14:12]), .funct7b5D(instr[30]),
        .funct7b1D(instr[25]), .immb10D(instr[30]),
        .PCTargetSrcD(pct_m), .ResultSrcD(res_m), .MemWriteD(mw_m), .JumpD(j_m),
        .BranchD(br_m), .RegWriteD(rw_m), .CsrInstrIncD(inc_m), .AluControlD(alu_m),
        .AluSrcAD(sa_m), .AluSrcBD(sb_m), .ImmSrcD(imm_m), .StoreOpD(st_m),
        .LoadOpD(ld_m), .CsrOpD(csr_m), .illegal_o(ill_m), .illegal_seen(seen_m)
    );

    rv32_control_unit #(.HAS_M(1'b0)) dut_nom (
        .clk(clk), .resetn(resetn),
        .opD(instr[6:0]), .funct3D(instr[14:12]), .funct7b5D(instr[30]),
        .funct7b1D(instr[25]), .immb10D(instr[30]),
        .PCTargetSrcD(pct_n), .ResultSrcD(res_n), .MemWriteD(mw_n), .JumpD(j_n),
        .BranchD(br_n), .RegWriteD(rw_n), .CsrInstrIncD(inc_n), .AluControlD(alu_n),
        .AluSrcAD(sa_n), .AluSrcBD(sb_n), .ImmSrcD(imm_n), .StoreOpD(st_n),
        .LoadOpD(ld_n), .CsrOpD(csr_n), .illegal_o(ill_n), .illegal_seen(seen_n)
    );

    function automatic obs_t nop();
        obs_t o;
        o.regwrite = 1'b0; o.memwrite = 1'b0; o.jump = 1'b0; o.branch = 1'b0;
        o.inc = 1'b0; o.illegal = 1'b0;
        o.pct = PC_PLUS_IMM; o.res = RESULT_ALU; o.alu = ALU_ADD;
        o.srca = SRCA_RS1; o.srcb = SRCB_IMM; o.imm = IMM_I;
        o.st = STORE_SW; o.ld = LOAD_LW; o.csr = CSR_NONE;
        return o;
    endfunction

    function automatic obs_t legal(logic rw);
        obs_t o = nop();
        o.inc = 1'b1;
        o.regwrite = rw;
        return o;
    endfunction

    function automatic obs_t bad();
        obs_t o = nop();
        o.illegal = 1'b1;
        return o;
    endfunction

    function automatic obs_t rtype(AluControl_t a);
        obs_t o = legal(1'b1);
        o.alu = a;
        o.srcb = SRCB_RS2;
        return o;
    endfunction

    function automatic vec_t mk(logic [31:0] ins, obs_t e, bit nom, string name);
        vec_t v;
        v.ins = ins; v.exp = e; v.nom = nom; v.name = name;
        return v;
    endfunction

    task automatic test_reset();
        vec_t v;
        obs_t e, got;
        e = legal(1'b0);
        e.inc = 1'b0;
        resetn = 1'b1;
        instr = 32'h00A00093;
        sbq.push_back(mk(instr, e, 1'b0, "reset_addi"));
        seenq.push_back(1'b0);
        @(posedge clk); #1;
        v = sbq.pop_front();
        got = got_m;
        checks++;
        if (got !== v.exp) $display("FAIL %s: got %h expected %h", v.name, got, v.exp);
        else passed++;
        checks++;
        if (seen_m !== seenq[0]) $display("FAIL reset_seen: got %b expected %b", seen_m, seenq[0]);
        else passed++;
        void'(seenq.pop_front());
        resetn = 1'b0;
    endtask

    task automatic test_alu_ops();
        vec_t vs[$];
        vec_t v;
        obs_t e, got;
        vs.push_back(mk(32'h00A00093, legal(1'b1), 1'b0, "addi"));
        vs.push_back(mk(32'h40008093, legal(1'b1), 1'b0, "addi_b30_no_subi"));
        e = legal(1'b1); e.alu = ALU_SRA; vs.push_back(mk(32'h4010D093, e, 1'b0, "srai"));
        e = legal(1'b1); e.alu = ALU_SRL; vs.push_back(mk(32'h0010D093, e, 1'b0, "srli"));
        e = legal(1'b1); e.alu = ALU_SLT; vs.push_back(mk(32'h0050A093, e, 1'b0, "slti"));
        vs.push_back(mk(32'h40208033, rtype(ALU_SUB), 1'b0, "sub"));
        vs.push_back(mk(32'h4020D0B3, rtype(ALU_SRA), 1'b0, "sra"));
        vs.push_back(mk(32'h0020C0B3, rtype(ALU_XOR), 1'b0, "xor"));
        vs.push_back(mk(32'h022081B3, rtype(ALU_MUL), 1'b0, "mul"));
        vs.push_back(mk(32'h0220D0B3, rtype(ALU_DIVU), 1'b0, "divu"));
        vs.push_back(mk(32'h0220F0B3, rtype(ALU_REMU), 1'b0, "remu"));
        e = legal(1'b1); e.srca = SRCA_ZERO; e.imm = IMM_U; vs.push_back(mk(32'h000010B7, e, 1'b0, "lui"));
        e = legal(1'b1); e.srca = SRCA_PC; e.imm = IMM_U; vs.push_back(mk(32'h00001097, e, 1'b0, "auipc"));
        foreach (vs[i]) begin
            instr = vs[i].ins;
            sbq.push_back(vs[i]);
            @(posedge clk); #1;
            v = sbq.pop_front();
            got = v.nom ? got_n : got_m;
            checks++;
            if (got !== v.exp) $display("FAIL %s: got %h expected %h", v.name, got, v.exp);
            else passed++;
        end
    endtask

    task automatic test_control_flow();
        vec_t vs[$];
        vec_t v;
        obs_t e, got;
        e = legal(1'b1); e.imm = IMM_J; e.jump = 1'b1; e.res = RESULT_PC4;
        vs.push_back(mk(32'h00C0006F, e, 1'b0, "jal"));
        e = legal(1'b1); e.jump = 1'b1; e.res = RESULT_PC4; e.pct = ALU_RESULT;
        vs.push_back(mk(32'h000080E7, e, 1'b0, "jalr"));
        e = legal(1'b0); e.branch = 1'b1; e.imm = IMM_B; e.srcb = SRCB_RS2; e.alu = ALU_BGE;
        vs.push_back(mk(32'h0020D463, e, 1'b0, "bge"));
        e.alu = ALU_BLTU;
        vs.push_back(mk(32'h0020E463, e, 1'b0, "bltu"));
        vs.push_back(mk(32'h0020A463, bad(), 1'b0, "branch_f3_010"));
        foreach (vs[i]) begin
            instr = vs[i].ins;
            sbq.push_back(vs[i]);
            @(posedge clk); #1;
            v = sbq.pop_front();
            got = v.nom ? got_n : got_m;
            checks++;
            if (got !== v.exp) $display("FAIL %s: got %h expected %h", v.name, got, v.exp);
            else passed++;
        end
    endtask

    task automatic test_memory();
        vec_t vs[$];
        vec_t v;
        obs_t e, got;
        e = legal(1'b0); e.memwrite = 1'b1; e.imm = IMM_S; e.st = STORE_SW;
        vs.push_back(mk(32'h0020A223, e, 1'b0, "sw"));
        e.st = STORE_SB;
        vs.push_back(mk(32'h00208023, e, 1'b0, "sb"));
        e = legal(1'b1); e.res = RESULT_MEM; e.ld = LOAD_LBU;
        vs.push_back(mk(32'h0040C083, e, 1'b0, "lbu"));
        e.ld = LOAD_LH;
        vs.push_back(mk(32'h00009083, e, 1'b0, "lh"));
        vs.push_back(mk(32'h0000B083, bad(), 1'b0, "load_f3_011"));
        vs.push_back(mk(32'h0000B023, bad(), 1'b0, "store_f3_011"));
        foreach (vs[i]) begin
            instr = vs[i].ins;
            sbq.push_back(vs[i]);
            @(posedge clk); #1;
            v = sbq.pop_front();
            got = v.nom ? got_n : got_m;
            checks++;
            if (got !== v.exp) $display("FAIL %s: got %h expected %h", v.name, got, v.exp);
            else passed++;
        end
    endtask

    task automatic test_system();
        vec_t vs[$];
        vec_t v;
        obs_t e, got;
        e = legal(1'b1); e.res = RESULT_CSR; e.csr = CSR_RW;
        vs.push_back(mk(32'h30029073, e, 1'b0, "csrrw"));
        e.csr = CSR_RCI;
        vs.push_back(mk(32'h3000F073, e, 1'b0, "csrrci"));
        vs.push_back(mk(32'h00000073, legal(1'b0), 1'b0, "ecall"));
        vs.push_back(mk(32'h0000000F, legal(1'b0), 1'b0, "fence"));
        vs.push_back(mk(32'h00000000, nop(), 1'b0, "bubble"));
        vs.push_back(mk(32'hFFFFFFFF, bad(), 1'b0, "all_ones"));
        foreach (vs[i]) begin
            instr = vs[i].ins;
            sbq.push_back(vs[i]);
            @(posedge clk); #1;
            v = sbq.pop_front();
            got = v.nom ? got_n : got_m;
            checks++;
            if (got !== v.exp) $display("FAIL %s: got %h expected %h", v.name, got, v.exp);
            else passed++;
        end
        instr = '0;
    endtask

    task automatic test_has_m();
        vec_t vs[$];
        vec_t v;
        obs_t got;
        vs.push_back(mk(32'h022081B3, bad(), 1'b1, "nom_mul"));
        vs.push_back(mk(32'h40208033, rtype(ALU_SUB), 1'b1, "nom_sub"));
        vs.push_back(mk(32'h0220D0B3, bad(), 1'b1, "nom_divu"));
        foreach (vs[i]) begin
            instr = vs[i].ins;
            sbq.push_back(vs[i]);
            @(posedge clk); #1;
            v = sbq.pop_front();
            got = v.nom ? got_n : got_m;
            checks++;
            if (got !== v.exp) $display("FAIL %s: got %h expected %h", v.name, got, v.exp);
            else passed++;
        end
        instr = '0;
    endtask

    // Each step: {resetn, instr} held across one edge, then illegal_seen compared
    task automatic test_sticky();
        logic        rst_seq[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] ins_seq[7]  = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'h00A00093,
                                     32'h00A00093, 32'hFFFFFFFF, 32'h0};
        logic        exp_seq[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        e;
        for (int i = 0; i < 7; i++) begin
            resetn = rst_seq[i];
            instr  = ins_seq[i];
            seenq.push_back(exp_seq[i]);
            @(posedge clk); #1;
            e = seenq.pop_front();
            checks++;
            if (seen_m !== e) $display("FAIL sticky_step%0d: got %b expected %b", i, seen_m, e);
            else passed++;
        end
        resetn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_control_flow();
        test_memory();
        test_system();
        test_has_m();
        test_sticky();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
